uart_bytes_to_packets: RTL and testbench
========================================

Name: uart_bytes_to_packets

Overview:
Converts the Avalon-ST byte stream from the UART receive path into an Avalon-ST packet stream with SOP, EOP and channel.
- Sits directly downstream of the UART receiver's byte output (out_valid/out_ready/out_data).
- Decodes the host byte protocol:
  - 0x7A = SOP marker
  - 0x7B = EOP marker
  - 0x7C = channel marker
  - 0x7D = escape; the next byte is XORed with 0x20
- Control bytes are consumed silently. Only data bytes produce output beats.

Parameters:
CHANNEL_WIDTH, 8, width of out_channel; legal range 1..8. The channel byte is truncated to its LSBs.

Ports:
clk  in  1  single clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high reset.
in_ready  out  1  byte sink ready; connects to the receiver's out_ready.
in_valid  in  1  byte valid.
in_data  in  8  byte.
out_ready  in  1  packet sink ready.
out_valid  out  1  packet beat valid.
out_data  out  8  decoded data byte.
out_startofpacket  out  1  first beat of packet.
out_endofpacket  out  1  last beat of packet.
out_channel  out  CHANNEL_WIDTH  channel of the beat.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high (reset). No clock enable.
- Reset values:
  - out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0.
  - State=NORMAL; sop_pend=0, eop_pend=0, chan_reg=0.
  - in_ready=1 after reset (it is derived from out_valid).
- Handshake:
  - Single output register.
  - in_ready = !out_valid || out_ready (combinational).
  - An input byte is accepted when in_valid && in_ready.
  - Output beat transfers when out_valid && out_ready.
  - out_* are held stable while out_valid && !out_ready.
- Latency: a data byte accepted in cycle N appears with out_valid=1 in cycle N+1. Full throughput of 1 byte/clk when out_ready is held high.
- Decode state machine (advances only on an accepted byte):
  - NORMAL:
    - 0x7A → sop_pend=1.
    - 0x7B → eop_pend=1.
    - 0x7C → CHAN.
    - 0x7D → ESC.
    - Any other byte → emit beat: data=byte, sop=sop_pend, eop=eop_pend, channel=chan_reg. Then clear sop_pend and eop_pend.
  - ESC: any byte → emit beat with data=byte^0x20 and the same flag rules as above; return to NORMAL.
  - CHAN:
    - 0x7D → CHAN_ESC.
    - Any other byte → chan_reg=byte[CHANNEL_WIDTH-1:0]; go to NORMAL.
  - CHAN_ESC: chan_reg=(byte^0x20)[CHANNEL_WIDTH-1:0]; go to NORMAL.
- Emitting a beat loads the output register and sets out_valid=1. Accepting a byte that does not emit clears out_valid if the previous beat transferred this cycle.
- Boundary conditions:
  - Repeated 0x7A or 0x7B before a data byte: the flag stays set (idempotent).
  - SOP and EOP both pending: a single-beat packet with both flags set.
  - Control bytes inside CHAN are channel values, not markers (except 0x7D, which escapes). An escaped control value in ESC is plain data (0x7D,0x5A → data 0x7A).
  - chan_reg persists across packets until the next channel marker.
  - Output stalled (out_valid && !out_ready): in_ready=0. No bytes are consumed, so state and pending flags are frozen.
  - Reset mid-escape or mid-channel: everything returns to reset values. A partially received sequence is discarded.

Optional Feature:
Macro UART_B2P_ERROR_EN.
- Defined:
  - Adds port out_error, out, 1 bit.
  - Adds internal in_packet flag: set on a beat with SOP, cleared on a beat with EOP.
  - out_error=1 accompanies a beat when either of these holds:
    - SOP on a beat while in_packet=1 (missing EOP).
    - A beat without SOP while in_packet=0 (missing SOP).
  - out_error resets to 0 and is held stable with the other out_* signals.
- Undefined: the port and in_packet logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package uart_stream_pkg holds:
  - Localparams SOP_CHAR=8'h7A, EOP_CHAR=8'h7B, CHANNEL_CHAR=8'h7C, ESCAPE_CHAR=8'h7D, ESCAPE_XOR=8'h20.
  - State encoding NORMAL/ESC/CHAN/CHAN_ESC.
  - These are reused by the future packets-to-bytes encoder on the transmit side.
- Single flat module; no sub-module is warranted.

Test Plan:
1. out_ready=1; bytes 7A,7C,03,11,22,7B,33 → three beats: (11, sop=1, eop=0, ch=3), (22, 0, 0, 3), (33, 0, 1, 3); first beat one cycle after byte 11 is accepted.
2. Bytes 7A,7B,7D,5D → single beat, data=7D, sop=1, eop=1.
3. Bytes 7C,7D,5C,44 → beat data=44, ch=0x7C (CHANNEL_WIDTH=8). Same sequence with CHANNEL_WIDTH=2 → ch=0.
4. out_ready=0 after first beat of 11,22 → in_ready=0, out_data holds 11. Release after 5 cycles → 11 then 22 in order, no loss or duplication.
5. Assert reset after 7A,7D is accepted, then send 41 → beat data=41, sop=0; all outputs are 0 during reset.
6. UART_B2P_ERROR_EN defined: 7A,01,7A,02 → beat 02 has out_error=1. A lone byte 05 after EOP → out_error=1.

Source files
------------

// File: rtl/uart_stream_pkg.sv
// Shared byte-protocol constants and decoder state encoding for the UART
// stream converters (bytes-to-packets here, packets-to-bytes on transmit).
package uart_stream_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SOP_CHAR     = 8'h7A;
  localparam logic [BYTE_W-1:0] EOP_CHAR     = 8'h7B;
  localparam logic [BYTE_W-1:0] CHANNEL_CHAR = 8'h7C;
  localparam logic [BYTE_W-1:0] ESCAPE_CHAR  = 8'h7D;
  localparam logic [BYTE_W-1:0] ESCAPE_XOR   = 8'h20;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    ESC      = 2'd1,
    CHAN     = 2'd2,
    CHAN_ESC = 2'd3
  } state_t;

endpackage

// File: rtl/uart_bytes_to_packets_if.sv
// Byte-sink and packet-source handshake bundle of the bytes-to-packets decoder.
// Optional out_error exists only when UART_B2P_ERROR_EN is defined.
// master: the decoder; slave: the surrounding byte source / packet sink.
interface uart_bytes_to_packets_if #(
  parameter int unsigned CHANNEL_WIDTH = 8
);
  import uart_stream_pkg::*;

  logic                     in_ready;
  logic                     in_valid;
  logic [BYTE_W-1:0]        in_data;
  logic                     out_ready;
  logic                     out_valid;
  logic [BYTE_W-1:0]        out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [CHANNEL_WIDTH-1:0] out_channel;
`ifdef UART_B2P_ERROR_EN
  logic                     out_error;
`endif

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
`ifdef UART_B2P_ERROR_EN
    , output out_error
`endif
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
`ifdef UART_B2P_ERROR_EN
    , input out_error
`endif
  );

endinterface

// File: rtl/uart_bytes_to_packets.sv
// Decodes the UART host byte protocol (SOP/EOP/channel markers, escape) into
// an Avalon-ST packet stream through a single output register.
// Optional packet framing error flag: define UART_B2P_ERROR_EN.
module uart_bytes_to_packets
  import uart_stream_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  uart_bytes_to_packets_if.master bus
);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_sop_pend;
  logic                     r_eop_pend;
  logic [CHANNEL_WIDTH-1:0] r_chan;

  logic                     r_out_valid;
  logic [BYTE_W-1:0]        r_out_data;
  logic                     r_out_sop;
  logic                     r_out_eop;
  logic [CHANNEL_WIDTH-1:0] r_out_chan;

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_emit;
  logic [BYTE_W-1:0]        w_beat_data;
  logic                     w_sop_pend_nxt;
  logic                     w_eop_pend_nxt;
  logic [CHANNEL_WIDTH-1:0] w_chan_nxt;

  // Input is taken whenever the output register is empty or draining
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Decode state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= NORMAL;
    else       r_state <= w_state_nxt;
  end

  // Next decode state, advancing only on an accepted byte
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      case (r_state)
        NORMAL: begin
          if (bus.in_data == CHANNEL_CHAR)     w_state_nxt = CHAN;
          else if (bus.in_data == ESCAPE_CHAR) w_state_nxt = ESC;
        end
        ESC:      w_state_nxt = NORMAL;
        CHAN:     w_state_nxt = (bus.in_data == ESCAPE_CHAR) ? CHAN_ESC : NORMAL;
        CHAN_ESC: w_state_nxt = NORMAL;
        default:  w_state_nxt = NORMAL;
      endcase
    end
  end

  // Per-byte action: beat emission, pending flag and channel updates
  always_comb begin
    w_emit         = 1'b0;
    w_beat_data    = bus.in_data;
    w_sop_pend_nxt = r_sop_pend;
    w_eop_pend_nxt = r_eop_pend;
    w_chan_nxt     = r_chan;
    if (w_accept) begin
      case (r_state)
        NORMAL: begin
          if (bus.in_data == SOP_CHAR)      w_sop_pend_nxt = 1'b1;
          else if (bus.in_data == EOP_CHAR) w_eop_pend_nxt = 1'b1;
          else if ((bus.in_data != CHANNEL_CHAR) && (bus.in_data != ESCAPE_CHAR))
            w_emit = 1'b1;
        end
        ESC: begin
          w_emit      = 1'b1;
          w_beat_data = bus.in_data ^ ESCAPE_XOR;
        end
        CHAN: begin
          if (bus.in_data != ESCAPE_CHAR) w_chan_nxt = CHANNEL_WIDTH'(bus.in_data);
        end
        CHAN_ESC: w_chan_nxt = CHANNEL_WIDTH'(bus.in_data ^ ESCAPE_XOR);
        default: ;
      endcase
    end
    if (w_emit) begin
      w_sop_pend_nxt = 1'b0;
      w_eop_pend_nxt = 1'b0;
    end
  end

  // Pending flags, channel register and the single output beat register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sop_pend  <= 1'b0;
      r_eop_pend  <= 1'b0;
      r_chan      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_chan  <= '0;
    end else begin
      r_sop_pend <= w_sop_pend_nxt;
      r_eop_pend <= w_eop_pend_nxt;
      r_chan     <= w_chan_nxt;
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_beat_data;
        r_out_sop   <= r_sop_pend;
        r_out_eop   <= r_eop_pend;
        r_out_chan  <= r_chan;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef UART_B2P_ERROR_EN
  logic r_in_packet;
  logic r_out_error;

  // Track packet framing; flag SOP inside a packet or data outside one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_packet <= 1'b0;
      r_out_error <= 1'b0;
    end else if (w_emit) begin
      r_out_error <= r_sop_pend ? r_in_packet : !r_in_packet;
      if (r_eop_pend)      r_in_packet <= 1'b0;
      else if (r_sop_pend) r_in_packet <= 1'b1;
    end
  end

  assign bus.out_error = r_out_error;
`endif

  assign bus.in_ready          = w_in_ready;
  assign bus.out_valid         = r_out_valid;
  assign bus.out_data          = r_out_data;
  assign bus.out_startofpacket = r_out_sop;
  assign bus.out_endofpacket   = r_out_eop;
  assign bus.out_channel       = r_out_chan;

endmodule

// File: tb/tb_uart_bytes_to_packets.sv
// Bench for uart_bytes_to_packets: two instances (CHANNEL_WIDTH 8 and 2) fed
// the same byte stream, checked against a lookahead parser of the protocol.
module tb_uart_bytes_to_packets;

  typedef logic [7:0] byte_q_t[$];

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [7:0] ch8;
    logic [1:0] ch2;
    logic       err;
  } beat_t;

  typedef beat_t beat_q_t[$];

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic       m_sop;
  logic       m_eop;
  logic [7:0] m_chan;
  logic       m_inpkt;

  uart_bytes_to_packets_if #(.CHANNEL_WIDTH(8)) bus8 ();
  uart_bytes_to_packets_if #(.CHANNEL_WIDTH(2)) bus2 ();

  assign bus8.in_valid  = in_valid;
  assign bus8.in_data   = in_data;
  assign bus8.out_ready = out_ready;
  assign bus2.in_valid  = in_valid;
  assign bus2.in_data   = in_data;
  assign bus2.out_ready = out_ready;

  uart_bytes_to_packets #(.CHANNEL_WIDTH(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
  uart_bytes_to_packets #(.CHANNEL_WIDTH(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_sop = 1'b0; m_eop = 1'b0; m_chan = 8'h00; m_inpkt = 1'b0;
  endfunction

  // Parse a complete byte sequence into expected beats using lookahead
  function automatic void model(input byte_q_t q, output beat_q_t exp_q);
    int i;
    logic [7:0] b;
    logic [7:0] c;
    logic emit;
    beat_t bt;
    exp_q = {};
    i = 0;
    while (i < q.size()) begin
      b = q[i];
      emit = 1'b0;
      if (b == 8'h7A) m_sop = 1'b1;
      else if (b == 8'h7B) m_eop = 1'b1;
      else if (b == 8'h7C) begin
        i++;
        c = q[i];
        if (c == 8'h7D) begin i++; c = q[i] ^ 8'h20; end
        m_chan = c;
      end else if (b == 8'h7D) begin
        i++; b = q[i] ^ 8'h20; emit = 1'b1;
      end else emit = 1'b1;
      if (emit) begin
        bt.data = b; bt.sop = m_sop; bt.eop = m_eop;
        bt.ch8 = m_chan; bt.ch2 = m_chan[1:0];
`ifdef UART_B2P_ERROR_EN
        bt.err = m_sop ? m_inpkt : !m_inpkt;
        if (m_eop) m_inpkt = 1'b0;
        else if (m_sop) m_inpkt = 1'b1;
`else
        bt.err = 1'b0;
`endif
        exp_q.push_back(bt);
        m_sop = 1'b0; m_eop = 1'b0;
      end
      i++;
    end
  endfunction

  function automatic beat_t sample();
    beat_t s;
    s.data = bus8.out_data;
    s.sop  = bus8.out_startofpacket;
    s.eop  = bus8.out_endofpacket;
    s.ch8  = bus8.out_channel;
    s.ch2  = bus2.out_channel;
`ifdef UART_B2P_ERROR_EN
    s.err  = bus8.out_error;
`else
    s.err  = 1'b0;
`endif
    return s;
  endfunction

  // Drive bytes with random gaps/backpressure; compare collected beats
  task automatic run_bytes(input byte_q_t bytes, input int vpct, input int rpct,
                           input string name, output beat_q_t got_q,
                           output int acc_cyc[$], output int first_valid_cyc);
    beat_q_t exp_q;
    int idx = 0;
    int cyc = 0;
    int k;
    model(bytes, exp_q);
    got_q = {};
    acc_cyc = {};
    first_valid_cyc = -1;
    while ((idx < bytes.size() || got_q.size() < exp_q.size()) && cyc < 4000) begin
      @(posedge clk); #1;
      in_valid  = (idx < bytes.size()) && ($urandom_range(99) < vpct);
      in_data   = (idx < bytes.size()) ? bytes[idx] : 8'($urandom);
      out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (bus8.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (in_valid && bus8.in_ready) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      if (bus8.out_valid && out_ready) begin
        k = got_q.size();
        if (k < exp_q.size()) begin
          checks++;
          if (sample() !== exp_q[k]) begin
            errors++;
            $display("FAIL %s beat%0d: got %h expected %h", name, k, sample(), exp_q[k]);
          end
          checks++;
          if ({bus2.out_data, bus2.out_startofpacket, bus2.out_endofpacket} !==
              {exp_q[k].data, exp_q[k].sop, exp_q[k].eop}) begin
            errors++;
            $display("FAIL %s w2_beat%0d: got %h expected %h", name, k,
                     {bus2.out_data, bus2.out_startofpacket, bus2.out_endofpacket},
                     {exp_q[k].data, exp_q[k].sop, exp_q[k].eop});
          end
        end
        got_q.push_back(sample());
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s beat_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (bus8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s drain_valid: got %b expected 0", name, bus8.out_valid);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if ({bus8.out_valid, bus8.out_data, bus8.out_startofpacket, bus8.out_endofpacket,
         bus8.out_channel, bus2.out_channel} !== 20'h0) begin
      errors++;
      $display("FAIL %s outputs: got %h expected 0", name,
               {bus8.out_valid, bus8.out_data, bus8.out_startofpacket, bus8.out_endofpacket,
                bus8.out_channel, bus2.out_channel});
    end
`ifdef UART_B2P_ERROR_EN
    checks++;
    if (bus8.out_error !== 1'b0) begin
      errors++;
      $display("FAIL %s out_error: got %b expected 0", name, bus8.out_error);
    end
`endif
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready: got %b expected 1", name, bus8.in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    beat_q_t got; int acc[$]; int fv;
    byte_q_t q = '{8'h7A, 8'h7C, 8'h03, 8'h11, 8'h22, 8'h7B, 8'h33};
    run_bytes(q, 100, 100, "basic", got, acc, fv);
    checks++;
    if (acc.size() < 4 || fv != acc[3] + 1) begin
      errors++;
      $display("FAIL basic latency: got first valid cycle %0d expected %0d", fv,
               (acc.size() < 4) ? -1 : acc[3] + 1);
    end
  endtask

  task automatic test_sop_eop_escape();
    beat_q_t got; int acc[$]; int fv;
    byte_q_t q = '{8'h7A, 8'h7B, 8'h7D, 8'h5D};
    run_bytes(q, 100, 100, "single_beat", got, acc, fv);
  endtask

  task automatic test_channel_escape();
    beat_q_t got; int acc[$]; int fv;
    byte_q_t q = '{8'h7C, 8'h7D, 8'h5C, 8'h44};
    run_bytes(q, 100, 100, "chan_escape", got, acc, fv);
  endtask

  task automatic test_stall();
    beat_q_t exp_q;
    beat_q_t got;
    byte_q_t q = '{8'h11, 8'h22};
    model(q, exp_q);
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    @(posedge clk); #1;
    in_data = 8'h22; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus8.in_ready, bus8.out_valid, bus8.out_data} !== {1'b0, 1'b1, 8'h11}) begin
        errors++;
        $display("FAIL stall_hold%0d: got rdy/vld/data %h expected %h", i,
                 {bus8.in_ready, bus8.out_valid, bus8.out_data}, {1'b0, 1'b1, 8'h11});
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus8.out_valid) got.push_back(sample());
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL stall_count: got %0d expected 2", got.size());
    end
    for (int i = 0; i < 2; i++) begin
      if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL stall_beat%0d: got %h expected %h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_escape();
    beat_q_t got; int acc[$]; int fv;
    byte_q_t q = '{8'h41};
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h7A;
    @(posedge clk); #1;
    in_data = 8'h7D;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_zero_outputs("reset_async");
    @(negedge clk);
    check_zero_outputs("reset_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    run_bytes(q, 100, 100, "after_reset", got, acc, fv);
  endtask

`ifdef UART_B2P_ERROR_EN
  task automatic test_error();
    beat_q_t got; int acc[$]; int fv;
    byte_q_t q = '{8'h7A, 8'h01, 8'h7A, 8'h02, 8'h7B, 8'h03, 8'h05};
    run_bytes(q, 100, 100, "error", got, acc, fv);
    if (got.size() == 4) begin
      checks++;
      if ({got[0].err, got[1].err, got[2].err, got[3].err} !== 4'b0101) begin
        errors++;
        $display("FAIL error_flags: got %b expected 0101",
                 {got[0].err, got[1].err, got[2].err, got[3].err});
      end
    end
  endtask
`endif

  // Random well-formed token streams: data (escaped when needed), markers, channels
  task automatic test_random(input int runs);
    beat_q_t got; int acc[$]; int fv;
    byte_q_t q;
    logic [7:0] v;
    for (int r = 0; r < runs; r++) begin
      q = {};
      for (int t = 0; t < 40; t++) begin
        v = 8'($urandom);
        if ($urandom_range(3) == 0) v = 8'h7A + 8'($urandom_range(3));
        case ($urandom_range(9))
          0: q.push_back(8'h7A);
          1: q.push_back(8'h7B);
          2: begin
            q.push_back(8'h7C);
            if (v == 8'h7D || $urandom_range(3) == 0) begin
              q.push_back(8'h7D); q.push_back(v ^ 8'h20);
            end else q.push_back(v);
          end
          default: begin
            if ((v >= 8'h7A && v <= 8'h7D) || $urandom_range(7) == 0) begin
              q.push_back(8'h7D); q.push_back(v ^ 8'h20);
            end else q.push_back(v);
          end
        endcase
      end
      run_bytes(q, 70, 60, $sformatf("random%0d", r), got, acc, fv);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sop_eop_escape();
    test_channel_escape();
    test_stall();
    test_reset_mid_escape();
`ifdef UART_B2P_ERROR_EN
    test_error();
`endif
    test_random(6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
